// File: rtl/lenet_seq_divider_u8.sv
// Iterative restoring divider: 2W-bit dividend by W-bit divisor, one quotient bit per cycle.
// Optional round-to-nearest quotient stage enabled by defining DIV_ROUND_EN.
module lenet_seq_divider_u8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] z,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf,
  output logic           dbz
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t        state, state_next;
  logic [W:0]    p, p_next;
  logic [W-1:0]  sh, sh_next;
  logic [W-1:0]  dvs, dvs_next;
  logic [W-1:0]  q_reg, q_next;
  logic [W-1:0]  r_reg, r_next;
  logic          ovf_reg, ovf_next;
  logic          dbz_reg, dbz_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [W:0]    p_shift;
  logic [W:0]    p_sub;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      p       <= '0;
      sh      <= '0;
      dvs     <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      ovf_reg <= 1'b0;
      dbz_reg <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      p       <= p_next;
      sh      <= sh_next;
      dvs     <= dvs_next;
      q_reg   <= q_next;
      r_reg   <= r_next;
      ovf_reg <= ovf_next;
      dbz_reg <= dbz_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    p_next     = p;
    sh_next    = sh;
    dvs_next   = dvs;
    q_next     = q_reg;
    r_next     = r_reg;
    ovf_next   = ovf_reg;
    dbz_next   = dbz_reg;
    cnt_next   = cnt;
    // p < dvs holds before each shift, so the shifted value fits in W+1 bits
    p_shift    = {p[W-1:0], sh[W-1]};
    p_sub      = p_shift - {1'b0, dvs};

    case (state)
      IDLE: begin
        if (in_valid) begin
          dvs_next = y;
          if (y == '0) begin
            dbz_next   = 1'b1;
            ovf_next   = 1'b0;
            q_next     = '1;
            r_next     = '0;
            state_next = DONE;
          end else if (z[2*W-1:W] >= y) begin
            dbz_next   = 1'b0;
            ovf_next   = 1'b1;
            q_next     = '1;
            r_next     = '0;
            state_next = DONE;
          end else begin
            dbz_next   = 1'b0;
            ovf_next   = 1'b0;
            p_next     = {1'b0, z[2*W-1:W]};
            sh_next    = z[W-1:0];
            q_next     = '0;
            r_next     = '0;
            cnt_next   = CW'(W - 1);
            state_next = CALC;
          end
        end
      end

      CALC: begin
        sh_next = sh << 1;
        if (p_shift >= {1'b0, dvs}) begin
          p_next = p_sub;
          q_next = {q_reg[W-2:0], 1'b1};
        end else begin
          p_next = p_shift;
          q_next = {q_reg[W-2:0], 1'b0};
        end
        cnt_next = cnt - CW'(1);
        if (cnt == '0) begin
          r_next = p_next[W-1:0];
`ifdef DIV_ROUND_EN
          state_next = ROUND;
`else
          state_next = DONE;
`endif
        end
      end

`ifdef DIV_ROUND_EN
      ROUND: begin
        // remainder stays unrounded; quotient saturates at all-ones
        if (({r_reg, 1'b0} >= {1'b0, dvs}) && (q_reg != '1))
          q_next = q_reg + 1'b1;
        state_next = DONE;
      end
`endif

      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q         = q_reg;
  assign r         = r_reg;
  assign ovf       = ovf_reg;
  assign dbz       = dbz_reg;

endmodule

// File: tb/tb_lenet_seq_divider_u8.sv
// Self-checking bench for lenet_seq_divider_u8 against an arithmetic z/y model.
// Honours DIV_ROUND_EN the same way the design does.
module tb_lenet_seq_divider_u8;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] z = '0;
  logic [W-1:0]   y = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           ovf;
  logic           dbz;

  int checks = 0;
  int failures = 0;

  lenet_seq_divider_u8 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Expected result straight from integer division; latency counted in edges after acceptance
  function automatic void model(input int zi, input int yi, output logic [W-1:0] eq,
                                output logic [W-1:0] er, output logic eo, output logic ed,
                                output int elat);
    int quo, rem;
    eo = 1'b0; ed = 1'b0; elat = 1;
    if (yi == 0) begin
      ed = 1'b1; eq = '1; er = '0;
    end else if (zi / yi > 255) begin
      eo = 1'b1; eq = '1; er = '0;
    end else begin
      quo = zi / yi;
      rem = zi % yi;
`ifdef DIV_ROUND_EN
      if (2 * rem >= yi && quo < 255) quo = quo + 1;
      elat = W + 2;
`else
      elat = W + 1;
`endif
      eq = quo[W-1:0];
      er = rem[W-1:0];
    end
  endfunction

  task automatic do_op(input logic [2*W-1:0] zi, input logic [W-1:0] yi, input int hold,
                       output logic [W-1:0] oq, output logic [W-1:0] orr, output logic oo,
                       output logic od, output int lat, output int unstable);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    z = zi; y = yi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    z = 16'($urandom); y = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      z = 16'($urandom); y = 8'($urandom);
    end
    oq = q; orr = r; oo = ovf; od = dbz;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      z = 16'($urandom); y = 8'($urandom);
      if (!out_valid || q !== oq || r !== orr || ovf !== oo || dbz !== od) unstable++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if ({in_ready, out_valid, q, r, ovf, dbz} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b q=%0d r=%0d ovf=%b dbz=%b want 1 0 0 0 0 0",
               in_ready, out_valid, q, r, ovf, dbz);
    end
  endtask

  task automatic test_directed();
    logic [2*W-1:0] zv[8] = '{16'd7400, 16'h1234, 16'd100, 16'hFFFF, 16'h0001,
                              16'hFF00, 16'hFEFF, 16'd0};
    logic [W-1:0]   yv[8] = '{8'd37, 8'h56, 8'd8, 8'h10, 8'd0, 8'hFF, 8'hFF, 8'd1};
    logic [W-1:0] gq, gr, eq, er;
    logic go, gd, eo, ed;
    int lat, elat, uns;
    for (int i = 0; i < 8; i++) begin
      model(int'(zv[i]), int'(yv[i]), eq, er, eo, ed, elat);
      do_op(zv[i], yv[i], i % 3, gq, gr, go, gd, lat, uns);
      checks++;
      if ({gq, gr, go, gd} !== {eq, er, eo, ed}) begin
        failures++;
        $display("[TB] FAIL directed_result z=%0d y=%0d got q=%0d r=%0d ovf=%b dbz=%b want q=%0d r=%0d ovf=%b dbz=%b",
                 zv[i], yv[i], gq, gr, go, gd, eq, er, eo, ed);
      end
      checks++;
      if (lat !== elat) begin
        failures++;
        $display("[TB] FAIL directed_latency z=%0d y=%0d got %0d want %0d", zv[i], yv[i], lat, elat);
      end
      checks++;
      if (uns !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL directed_handshake z=%0d got unstable=%0d vld=%b rdy=%b want 0 0 1",
                 zv[i], uns, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_hold_and_reset();
    logic [W-1:0] gq, gr, eq, er;
    logic go, gd, eo, ed;
    int lat, elat, uns, spurious;
    model(100, 8, eq, er, eo, ed, elat);
    do_op(16'd100, 8'd8, 20, gq, gr, go, gd, lat, uns);
    checks++;
    if (uns !== 0 || {gq, gr, go, gd} !== {eq, er, eo, ed}) begin
      failures++;
      $display("[TB] FAIL hold_stable got unstable=%0d q=%0d r=%0d want 0 q=%0d r=%0d",
               uns, gq, gr, eq, er);
    end
    z = 16'h1234; y = 8'h56; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 8'd0 || r !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midcalc_reset got vld=%b rdy=%b q=%0d r=%0d want 0 1 0 0",
               out_valid, in_ready, q, r);
    end
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("[TB] FAIL no_spurious_result got %0d valid cycles want 0", spurious);
    end
  endtask

  task automatic test_random();
    logic [2*W-1:0] zi;
    logic [W-1:0] yi, gq, gr, eq, er;
    logic go, gd, eo, ed;
    int lat, elat, uns, sel;
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      yi = (sel == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (sel < 7 && yi != 0) zi = 16'($urandom_range(0, int'(yi) * 256 - 1));
      else zi = 16'($urandom);
      model(int'(zi), int'(yi), eq, er, eo, ed, elat);
      do_op(zi, yi, int'($urandom_range(0, 3)), gq, gr, go, gd, lat, uns);
      checks++;
      if ({gq, gr, go, gd} !== {eq, er, eo, ed} || lat !== elat || uns !== 0) begin
        failures++;
        $display("[TB] FAIL random z=%0d y=%0d got q=%0d r=%0d ovf=%b dbz=%b lat=%0d uns=%0d want q=%0d r=%0d ovf=%b dbz=%b lat=%0d",
                 zi, yi, gq, gr, go, gd, lat, uns, eq, er, eo, ed, elat);
      end
    end
  endtask

  task automatic test_product_inverse();
    logic [W-1:0] yl[8];
    logic [W-1:0] gq, gr;
    logic go, gd;
    int lat, uns;
    yl[0] = 8'd1; yl[1] = 8'd2; yl[2] = 8'd3; yl[3] = 8'd255;
    for (int k = 4; k < 8; k++) yl[k] = 8'($urandom_range(4, 254));
    for (int k = 0; k < 8; k++) begin
      for (int x = 0; x < 256; x++) begin
        do_op(16'(x * int'(yl[k])), yl[k], 0, gq, gr, go, gd, lat, uns);
        checks++;
        if (gq !== 8'(x) || gr !== 8'd0 || go !== 1'b0 || gd !== 1'b0) begin
          failures++;
          $display("[TB] FAIL product_inverse x=%0d y=%0d got q=%0d r=%0d ovf=%b dbz=%b want q=%0d r=0",
                   x, yl[k], gq, gr, go, gd, x);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_and_reset();
    test_random();
    test_product_inverse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
